mac_result_display: RTL and testbench

MAC_RESULT_DISPLAY -- requirements
Module: mac_result_display

---
 rtl/mac_pkg.sv | 16 +
 rtl/hex_to_seg.sv | 30 +++
 rtl/mac_result_display.sv | 130 +++++++++++++
 tb/tb_mac_result_display.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC result display block.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DISPLAY = 2'd2
   } state_t;

   localparam int NUM_RES = 8;
   localparam int RES_W   = 24;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern (segment order g..a).
module hex_to_seg (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b1111111;
      unique case (nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/mac_result_display.sv
// Collects indexed MAC results into slots and shows the selected slot on six
// seven-segment digits; moves to DISPLAY once every slot is filled or upstream is done.
module mac_result_display #(
   parameter int NUM_RES = mac_pkg::NUM_RES,
   parameter int RES_W   = mac_pkg::RES_W
) (
   input  logic               CLOCK_50,
   input  logic               rst_n,
   input  logic               res_valid,
   input  logic [2:0]         res_idx,
   input  logic [RES_W-1:0]   res_data,
   output logic               res_ready,
   input  logic               all_done,
   input  logic               clr,
   input  logic [2:0]         sel,
   output logic [6:0]         HEX0,
   output logic [6:0]         HEX1,
   output logic [6:0]         HEX2,
   output logic [6:0]         HEX3,
   output logic [6:0]         HEX4,
   output logic [6:0]         HEX5,
   output logic [NUM_RES-1:0] valid_mask,
   output logic               done
);
   import mac_pkg::*;

   state_t             state_reg;
   logic               done_reg;
   logic [NUM_RES-1:0] mask_reg;
   logic [NUM_RES-1:0] mask_next;
   logic [NUM_RES-1:0] idx_onehot;
   logic [RES_W-1:0]   slot_reg [NUM_RES];
   logic               accept;
   logic               full_next;
   logic               sel_valid;
   logic [23:0]        disp_word;
   logic [6:0]         seg_dec [6];
   logic [6:0]         hex_reg [6];

   // clr wins over a simultaneous offer, so the offer is never accepted.
   always_comb begin
      idx_onehot = '0;
      if (int'(res_idx) < NUM_RES)
         idx_onehot[res_idx] = 1'b1;
      res_ready = (state_reg != DISPLAY);
      accept    = res_valid && res_ready && !clr && (|idx_onehot);
      mask_next = accept ? (mask_reg | idx_onehot) : mask_reg;
      full_next = &mask_next;
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         done_reg  <= 1'b0;
         mask_reg  <= '0;
      end else if (clr) begin
         state_reg <= IDLE;
         done_reg  <= 1'b0;
         mask_reg  <= '0;
      end else begin
         mask_reg <= mask_next;
         unique case (state_reg)
            IDLE: begin
               if (all_done || (accept && full_next)) begin
                  state_reg <= DISPLAY;
                  done_reg  <= 1'b1;
               end else if (accept) begin
                  state_reg <= COLLECT;
               end
            end
            COLLECT: begin
               if (full_next || all_done) begin
                  state_reg <= DISPLAY;
                  done_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= DISPLAY;
               done_reg  <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_RES; i++)
            slot_reg[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < NUM_RES; i++)
            slot_reg[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < NUM_RES; i++)
            if (idx_onehot[i])
               slot_reg[i] <= res_data;
      end
   end

   always_comb begin
      sel_valid = mask_reg[sel];
      disp_word = 24'(slot_reg[sel]);
   end

   // Digits are decoded from current slot contents and registered, giving one cycle of latency.
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_digit
         hex_to_seg u_dec (
            .nibble (disp_word[4*gi +: 4]),
            .seg    (seg_dec[gi])
         );

         always_ff @(posedge CLOCK_50 or negedge rst_n) begin
            if (!rst_n)
               hex_reg[gi] <= SEG_BLANK;
            else
               hex_reg[gi] <= sel_valid ? seg_dec[gi] : SEG_DASH;
         end
      end
   endgenerate

   assign HEX0       = hex_reg[0];
   assign HEX1       = hex_reg[1];
   assign HEX2       = hex_reg[2];
   assign HEX3       = hex_reg[3];
   assign HEX4       = hex_reg[4];
   assign HEX5       = hex_reg[5];
   assign valid_mask = mask_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_mac_result_display.sv
// Scoreboard bench for mac_result_display: a behavioural model queues expected
// outputs as stimulus is driven; they are popped and compared once the DUT responds.
module tb_mac_result_display;

   localparam int K_MASK  = 0;
   localparam int K_DONE  = 1;
   localparam int K_READY = 2;
   localparam int K_HEX   = 3;

   localparam logic [6:0]  DASH  = 7'b0111111;
   localparam logic [41:0] BLANK = {42{1'b1}};
   localparam logic [6:0]  SEG_TAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic        CLOCK_50;
   logic        rst_n;
   logic        res_valid;
   logic [2:0]  res_idx;
   logic [23:0] res_data;
   logic        res_ready;
   logic        all_done;
   logic        clr;
   logic [2:0]  sel;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [7:0]  valid_mask;
   logic        done;

   mac_result_display dut (
      .CLOCK_50   (CLOCK_50),
      .rst_n      (rst_n),
      .res_valid  (res_valid),
      .res_idx    (res_idx),
      .res_data   (res_data),
      .res_ready  (res_ready),
      .all_done   (all_done),
      .clr        (clr),
      .sel        (sel),
      .HEX0       (HEX0),
      .HEX1       (HEX1),
      .HEX2       (HEX2),
      .HEX3       (HEX3),
      .HEX4       (HEX4),
      .HEX5       (HEX5),
      .valid_mask (valid_mask),
      .done       (done)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_q  [$];
   int          kind_q [$];
   string       tag_q  [$];

   // Reference model: 0 = IDLE, 1 = COLLECT, 2 = DISPLAY.
   logic [23:0] m_slot [8];
   logic [7:0]  m_mask;
   int          m_state;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] observe(input int kind);
      case (kind)
         K_MASK:  return 64'(valid_mask);
         K_DONE:  return 64'(done);
         K_READY: return 64'(res_ready);
         default: return 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0});
      endcase
   endfunction

   task automatic push_exp(input string tag, input int kind, input logic [63:0] exp);
      tag_q.push_back(tag);
      kind_q.push_back(kind);
      exp_q.push_back(exp);
   endtask

   task automatic drain();
      while (kind_q.size() > 0) begin
         int          k;
         logic [63:0] e;
         string       t;
         k = kind_q.pop_front();
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_val(t, observe(k), e);
      end
   endtask

   function automatic logic [41:0] exp_hex(input logic [2:0] s);
      logic [41:0] w;
      for (int n = 0; n < 6; n++) begin
         if (m_mask[s])
            w[7*n +: 7] = SEG_TAB[m_slot[s][4*n +: 4]];
         else
            w[7*n +: 7] = DASH;
      end
      return w;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_slot[i] = '0;
      m_mask  = '0;
      m_state = 0;
   endtask

   task automatic push_ctrl(input string name);
      push_exp({name, "_mask"},  K_MASK,  64'(m_mask));
      push_exp({name, "_done"},  K_DONE,  64'(m_state == 2));
      push_exp({name, "_ready"}, K_READY, 64'(m_state != 2));
   endtask

   // One clock of stimulus; control outputs are compared just after the edge.
   task automatic step(input string name, input logic v, input logic [2:0] idx,
                       input logic [23:0] d, input logic ad, input logic c);
      logic acc;
      @(negedge CLOCK_50);
      res_valid = v; res_idx = idx; res_data = d; all_done = ad; clr = c;
      acc = v && (m_state != 2) && !c;
      if (c) begin
         model_clear();
      end else begin
         if (acc) begin
            m_slot[idx]  = d;
            m_mask[idx]  = 1'b1;
         end
         if (m_state == 0) begin
            if (ad || (acc && m_mask == 8'hFF)) m_state = 2;
            else if (acc)                       m_state = 1;
         end else if (m_state == 1) begin
            if (ad || m_mask == 8'hFF) m_state = 2;
         end
      end
      push_ctrl(name);
      @(posedge CLOCK_50);
      #1;
      $display("txn %s: valid=%0b idx=%0d data=%h all_done=%0b clr=%0b -> mask=%h done=%0b ready=%0b",
               name, v, idx, d, ad, c, valid_mask, done, res_ready);
      drain();
      res_valid = 1'b0; all_done = 1'b0; clr = 1'b0;
   endtask

   task automatic check_hex(input string name, input logic [2:0] s);
      @(negedge CLOCK_50);
      sel = s;
      push_exp(name, K_HEX, 64'(exp_hex(s)));
      @(posedge CLOCK_50);
      #1;
      $display("txn %s: sel=%0d hex=%h", name, s, {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0});
      drain();
   endtask

   initial begin
      rst_n = 1'b0; res_valid = 1'b0; res_idx = '0; res_data = '0;
      all_done = 1'b0; clr = 1'b0; sel = 3'd0;
      model_clear();
      #25;
      push_exp("rst_hex", K_HEX, 64'(BLANK));
      push_ctrl("rst");
      drain();
      @(negedge CLOCK_50);
      rst_n = 1'b1;

      // Fill all eight slots; the eighth accept lands in DISPLAY.
      for (int i = 0; i < 8; i++)
         step($sformatf("fill%0d", i), 1'b1, 3'(i), 24'(i + 1), 1'b0, 1'b0);
      check_hex("full_sel3", 3'd3);
      step("disp_ignore", 1'b1, 3'd5, 24'hFFFFFF, 1'b0, 1'b0);
      check_hex("full_sel5", 3'd5);

      // Single result then all_done.
      step("clr_a", 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
      check_hex("clr_a_sel3", 3'd3);
      step("one_idx2", 1'b1, 3'd2, 24'hABCDEF, 1'b0, 1'b0);
      step("one_done", 1'b0, 3'd0, 24'h0, 1'b1, 1'b0);
      check_hex("one_sel2", 3'd2);
      check_hex("one_sel5", 3'd5);

      // Overwrite of an already valid slot.
      step("clr_b", 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
      step("ovw_first", 1'b1, 3'd1, 24'h111111, 1'b0, 1'b0);
      step("ovw_second", 1'b1, 3'd1, 24'h222222, 1'b0, 1'b0);
      check_hex("ovw_sel1", 3'd1);

      // clr beats a simultaneous offer.
      step("clr_vs_acc", 1'b1, 3'd4, 24'h0000FF, 1'b0, 1'b1);
      check_hex("clr_vs_acc_sel4", 3'd4);

      // Asynchronous reset mid-COLLECT.
      step("pre_rst", 1'b1, 3'd6, 24'h123456, 1'b0, 1'b0);
      check_hex("pre_rst_sel6", 3'd6);
      @(posedge CLOCK_50);
      #3;
      rst_n = 1'b0;
      #1;
      model_clear();
      push_exp("async_rst_hex", K_HEX, 64'(BLANK));
      push_ctrl("async_rst");
      drain();
      $display("txn async_rst: mask=%h done=%0b", valid_mask, done);
      @(negedge CLOCK_50);
      rst_n = 1'b1;
      step("post_rst_acc", 1'b1, 3'd0, 24'h00000A, 1'b0, 1'b0);
      check_hex("post_rst_sel6", 3'd6);
      check_hex("post_rst_sel0", 3'd0);

      // Empty result set: all_done straight from IDLE.
      step("clr_c", 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
      step("empty_done", 1'b0, 3'd0, 24'h0, 1'b1, 1'b0);
      check_hex("empty_sel0", 3'd0);
      check_hex("empty_sel7", 3'd7);
      step("empty_stay", 1'b1, 3'd3, 24'h333333, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
